// File: rtl/retire_buffer_if.sv
// Commit-bundle field widths and the bus between CVA6 commit, retire_buffer and
// the retirement serializer.
package mure_pkg;
  localparam int NrRetiredInstr = 2;
  localparam int ITYPE_LEN      = 3;
  localparam int CAUSE_LEN      = 5;
  localparam int TVAL_LEN       = 32;
  localparam int PRIV_LEN       = 2;
  localparam int XLEN           = 32;

  typedef struct packed {
    logic [NrRetiredInstr-1:0]                iretire;
    logic [NrRetiredInstr-1:0]                ilastsize;
    logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0] itype;
    logic [CAUSE_LEN-1:0]                     cause;
    logic [TVAL_LEN-1:0]                      tval;
    logic [PRIV_LEN-1:0]                      priv;
    logic [NrRetiredInstr-1:0][XLEN-1:0]      iaddr;
  } bundle_t;
endpackage

// Handshake: the head bundle transfers on a rising clk edge where valid_o && ready_i;
// valid_o never depends on ready_i, and ready_i is ignored while valid_o is low.
interface retire_buffer_if #(
  parameter int DEPTH      = 4,
  parameter int DROP_CNT_W = 16
);
  import mure_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NrRetiredInstr-1:0]                iretire_i;
  logic [NrRetiredInstr-1:0]                ilastsize_i;
  logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0] itype_i;
  logic [CAUSE_LEN-1:0]                     cause_i;
  logic [TVAL_LEN-1:0]                      tval_i;
  logic [PRIV_LEN-1:0]                      priv_i;
  logic [NrRetiredInstr-1:0][XLEN-1:0]      iaddr_i;
  logic                                     ready_i;

  logic                                     valid_o;
  logic [NrRetiredInstr-1:0]                iretire_o;
  logic [NrRetiredInstr-1:0]                ilastsize_o;
  logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0] itype_o;
  logic [CAUSE_LEN-1:0]                     cause_o;
  logic [TVAL_LEN-1:0]                      tval_o;
  logic [PRIV_LEN-1:0]                      priv_o;
  logic [NrRetiredInstr-1:0][XLEN-1:0]      iaddr_o;
  logic [CW-1:0]                            count_o;
  logic                                     overflow_o;
  logic [DROP_CNT_W-1:0]                    drop_cnt_o;

  modport slave (
    input  iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
    output valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
           count_o, overflow_o, drop_cnt_o
  );

  modport master (
    output iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
    input  valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
           count_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/retire_buffer.sv
// Elastic FIFO of commit bundles; commit cannot stall, so overflow drops and counts.
// Optional RETIRE_BUFFER_BYPASS_EN: an empty buffer presents the incoming bundle combinationally.
module retire_buffer
  import mure_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DROP_CNT_W = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  retire_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  bundle_t               mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  overflow_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  bundle_t in_b, head_b, out_b;
  logic    in_v, empty, full, pop, push, drop, out_v;
  logic    byp, byp_take;

  always_comb begin
    in_b           = '0;
    in_b.iretire   = bus.iretire_i;
    in_b.ilastsize = bus.ilastsize_i;
    in_b.itype     = bus.itype_i;
    in_b.cause     = bus.cause_i;
    in_b.tval      = bus.tval_i;
    in_b.priv      = bus.priv_i;
    in_b.iaddr     = bus.iaddr_i;
  end

  // Exceptions and interrupts retire nothing but still carry a non-zero itype.
  assign in_v  = (|bus.iretire_i) || (|bus.itype_i);
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && bus.ready_i;

`ifdef RETIRE_BUFFER_BYPASS_EN
  assign byp      = empty && in_v && !rst_i;
  assign byp_take = byp && bus.ready_i;
`else
  assign byp      = 1'b0;
  assign byp_take = 1'b0;
`endif

  assign push = in_v && !byp_take && (!full || pop);
  assign drop = in_v && full && !pop;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_b;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (!(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign head_b = mem[rd_ptr[AW-1:0]];

  always_comb begin
    out_b = '0;
    out_v = 1'b0;
    if (byp) begin
      out_b = in_b;
      out_v = 1'b1;
    end else if (!empty) begin
      out_b = head_b;
      out_v = 1'b1;
    end
  end

  assign bus.valid_o     = out_v;
  assign bus.iretire_o   = out_b.iretire;
  assign bus.ilastsize_o = out_b.ilastsize;
  assign bus.itype_o     = out_b.itype;
  assign bus.cause_o     = out_b.cause;
  assign bus.tval_o      = out_b.tval;
  assign bus.priv_o      = out_b.priv;
  assign bus.iaddr_o     = out_b.iaddr;
  assign bus.count_o     = wr_ptr - rd_ptr;
  assign bus.overflow_o  = overflow_q;
  assign bus.drop_cnt_o  = drop_cnt_q;
endmodule

// File: tb/tb_retire_buffer.sv
// Bench for retire_buffer: directed scenarios plus random traffic against a queue model.
module tb_retire_buffer;
  import mure_pkg::*;

  localparam int DEPTH      = 4;
  localparam int DROP_CNT_W = 16;
  localparam int BW         = $bits(bundle_t);
  localparam int DROP_MAX   = (1 << DROP_CNT_W) - 1;

  logic clk;
  logic rst;

  retire_buffer_if #(.DEPTH(DEPTH), .DROP_CNT_W(DROP_CNT_W)) bus ();

  retire_buffer #(.DEPTH(DEPTH), .DROP_CNT_W(DROP_CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: bundles awaiting output, occupancy and drop bookkeeping
  logic [BW-1:0] exp_q[$];
  int occ, m_drop;
  bit m_ovf;
  int cur_occ, cur_drop;
  bit cur_ovf, cur_bypass;
  int checks, errors;

  function automatic bit bundle_valid(input bundle_t b);
    bit v;
    v = (b.iretire != '0);
    for (int s = 0; s < NrRetiredInstr; s++)
      if (b.itype[s] != '0) v = 1'b1;
    return v;
  endfunction

  function automatic bundle_t rand_bundle(input int pct_valid);
    bundle_t b;
    b.iretire   = NrRetiredInstr'($urandom);
    b.ilastsize = NrRetiredInstr'($urandom);
    for (int s = 0; s < NrRetiredInstr; s++) begin
      b.itype[s] = ($urandom_range(0, 1) == 1) ? ITYPE_LEN'($urandom_range(1, 7)) : '0;
      b.iaddr[s] = XLEN'($urandom);
    end
    b.cause = CAUSE_LEN'($urandom);
    b.tval  = TVAL_LEN'($urandom);
    b.priv  = PRIV_LEN'($urandom);
    if ($urandom_range(0, 99) >= pct_valid) begin
      b.iretire = '0;
      b.itype   = '0;
    end
    return b;
  endfunction

  function automatic bundle_t rand_valid_bundle();
    bundle_t b;
    b = rand_bundle(100);
    b.iretire = NrRetiredInstr'($urandom_range(1, 3));
    return b;
  endfunction

  function automatic bundle_t dut_out();
    bundle_t b;
    b.iretire   = bus.iretire_o;
    b.ilastsize = bus.ilastsize_o;
    b.itype     = bus.itype_o;
    b.cause     = bus.cause_o;
    b.tval      = bus.tval_o;
    b.priv      = bus.priv_o;
    b.iaddr     = bus.iaddr_o;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_bundle(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_inputs(input bundle_t b, input logic rdy);
    bus.iretire_i   = b.iretire;
    bus.ilastsize_i = b.ilastsize;
    bus.itype_i     = b.itype;
    bus.cause_i     = b.cause;
    bus.tval_i      = b.tval;
    bus.priv_i      = b.priv;
    bus.iaddr_i     = b.iaddr;
    bus.ready_i     = rdy;
  endtask

  // driver: one cycle of stimulus; the model predicts the effect of the coming edge
  task automatic step(input bundle_t b, input logic rdy);
    bit inv, pop;
    @(posedge clk);
    #2;
    drive_inputs(b, rdy);
    cur_occ    = occ;
    cur_ovf    = m_ovf;
    cur_drop   = m_drop;
    cur_bypass = 1'b0;
    inv = bundle_valid(b);
    pop = (occ > 0) && rdy;
`ifdef RETIRE_BUFFER_BYPASS_EN
    if (occ == 0 && inv) begin
      cur_bypass = 1'b1;
      exp_q.push_back(b);
      if (!rdy) occ = 1;
    end else
`endif
    if (inv) begin
      if (occ < DEPTH || pop) begin
        exp_q.push_back(b);
        occ++;
      end else begin
        m_ovf = 1'b1;
        if (m_drop < DROP_MAX) m_drop++;
      end
    end
    if (pop) occ--;
  endtask

  task automatic mid_cycle_reset();
    bundle_t z;
    z = '0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    drive_inputs(z, 1'b0);
    exp_q.delete();
    occ = 0; m_ovf = 1'b0; m_drop = 0;
    cur_occ = 0; cur_ovf = 1'b0; cur_drop = 0; cur_bypass = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_count", 64'(bus.count_o), 64'd0);
    chk("rst_overflow", 64'(bus.overflow_o), 64'd0);
    chk("rst_drop_cnt", 64'(bus.drop_cnt_o), 64'd0);
    chk_bundle("rst_data", dut_out(), '0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // monitor / scoreboard: compares the visible state and head bundle each cycle
  always @(negedge clk) begin
    bit exp_valid;
    chk("count", 64'(bus.count_o), 64'(cur_occ));
    chk("overflow", 64'(bus.overflow_o), 64'(cur_ovf));
    chk("drop_cnt", 64'(bus.drop_cnt_o), 64'(cur_drop));
    exp_valid = (cur_occ > 0) || cur_bypass;
    chk("valid", 64'(bus.valid_o), 64'(exp_valid));
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head: actual %h required <empty model queue>", dut_out());
      end else begin
        chk_bundle("head", dut_out(), exp_q[0]);
        if (bus.ready_i) void'(exp_q.pop_front());
      end
    end else begin
      chk_bundle("idle_data", dut_out(), '0);
    end
  end

  initial begin
    bundle_t z, b;
    int rp, ip;
    checks = 0; errors = 0;
    occ = 0; m_ovf = 1'b0; m_drop = 0;
    cur_occ = 0; cur_ovf = 1'b0; cur_drop = 0; cur_bypass = 1'b0;
    z = '0;
    rst = 1'b1;
    drive_inputs(z, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    chk("init_valid", 64'(bus.valid_o), 64'd0);
    chk("init_count", 64'(bus.count_o), 64'd0);
    rst = 1'b0;

    // single bundle, held then consumed
    b = z;
    b.iretire  = 2'b11;
    b.iaddr[1] = 32'h84;
    b.iaddr[0] = 32'h80;
    step(b, 1'b0);
    step(z, 1'b0);
    #1;
    chk("single_valid", 64'(bus.valid_o), 64'd1);
    chk("single_iaddr", 64'(bus.iaddr_o), {32'h84, 32'h80});
    step(z, 1'b1);
    step(z, 1'b0);
    #1;
    chk("single_drained", 64'(bus.valid_o), 64'd0);

    // fill with six bundles, two are dropped
    for (int i = 0; i < 6; i++) step(rand_valid_bundle(), 1'b0);
    step(z, 1'b0);
    #1;
    chk("fill_count", 64'(bus.count_o), 64'd4);
    chk("fill_overflow", 64'(bus.overflow_o), 64'd1);
    chk("fill_drop_cnt", 64'(bus.drop_cnt_o), 64'd2);

    // full with simultaneous push and pop
    step(rand_valid_bundle(), 1'b1);
    step(z, 1'b0);
    #1;
    chk("full_sim_count", 64'(bus.count_o), 64'd4);
    chk("full_sim_drop_cnt", 64'(bus.drop_cnt_o), 64'd2);
    repeat (6) step(z, 1'b1);

    // exception-only bundle, then an all-zero input
    b = z;
    b.itype[0] = 3'd1;
    b.cause    = 5'd2;
    b.tval     = 32'hDEAD;
    step(b, 1'b0);
    step(z, 1'b0);
    #1;
    chk("exc_valid", 64'(bus.valid_o), 64'd1);
    chk("exc_cause", 64'(bus.cause_o), 64'd2);
    chk("exc_tval", 64'(bus.tval_o), 64'hDEAD);
    step(z, 1'b0);
    #1;
    chk("zero_not_pushed", 64'(bus.count_o), 64'd1);
    repeat (2) step(z, 1'b1);

    // empty buffer, input valid with ready high
    step(rand_valid_bundle(), 1'b1);
    #1;
`ifdef RETIRE_BUFFER_BYPASS_EN
    chk("bypass_same_cycle_valid", 64'(bus.valid_o), 64'd1);
    step(z, 1'b0);
    #1;
    chk("bypass_count", 64'(bus.count_o), 64'd0);
`else
    chk("nobypass_same_cycle_valid", 64'(bus.valid_o), 64'd0);
    step(z, 1'b0);
    #1;
    chk("nobypass_next_valid", 64'(bus.valid_o), 64'd1);
`endif
    repeat (2) step(z, 1'b1);

    // reset in the middle of operation
    for (int i = 0; i < 3; i++) step(rand_valid_bundle(), 1'b0);
    mid_cycle_reset();
    step(z, 1'b0);
    #1;
    chk("post_rst_count", 64'(bus.count_o), 64'd0);

    // random traffic with varying input and ready densities
    for (int blk = 0; blk < 20; blk++) begin
      rp = $urandom_range(0, 100);
      ip = $urandom_range(10, 100);
      for (int c = 0; c < 100; c++)
        step(rand_bundle(ip), 1'($urandom_range(0, 99) < rp));
    end

    repeat (8) step(z, 1'b1);
    step(z, 1'b0);
    #1;
    chk("final_count", 64'(bus.count_o), 64'd0);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
